// File: rtl/sipo_rx.sv
// Serial-in, parallel-out receiver: rebuilds MSB-first WIDTH-bit words from a qualified bit stream.
// Define SIPO_PARITY_EN to append an even-parity bit to each frame and report parity_err.
module sipo_rx #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sin,
    input  logic             sin_valid,
    input  logic             sin_start,
    output logic [WIDTH-1:0] pout,
    output logic             pout_valid,
    input  logic             pout_ready,
    output logic             busy,
    output logic             overrun,
    input  logic             overrun_clr,
    output logic             parity_err
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

`ifdef SIPO_PARITY_EN
    localparam int SRW = WIDTH;
`else
    // The final data bit goes straight from sin into pout, so only WIDTH-1 bits need storing.
    localparam int SRW = WIDTH - 1;
`endif

    typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;

    state_t           state_reg;
    logic [CW-1:0]    cnt_reg;
    logic [SRW-1:0]   sr_reg;
    logic [WIDTH-1:0] frame_word;
    logic             slot_free;

`ifdef SIPO_PARITY_EN
    logic             parity_reg;
    logic             frame_par;

    assign frame_word = sr_reg;
    assign frame_par  = ^{sr_reg, sin};
    assign parity_err = parity_reg;
`else
    assign frame_word = {sr_reg, sin};
    assign parity_err = 1'b0;
`endif

    // A slot being accepted on this edge counts as free for a completing word.
    assign slot_free = !pout_valid || pout_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg  <= IDLE;
            cnt_reg    <= '0;
            sr_reg     <= '0;
            pout       <= '0;
            pout_valid <= 1'b0;
            busy       <= 1'b0;
            overrun    <= 1'b0;
`ifdef SIPO_PARITY_EN
            parity_reg <= 1'b0;
`endif
        end else begin
            // Later assignments below (a new drop) override the clear on the same edge.
            if (overrun_clr) begin
                overrun <= 1'b0;
            end
            if (pout_valid && pout_ready) begin
                pout_valid <= 1'b0;
            end

            if (sin_valid) begin
                if (sin_start || state_reg == IDLE) begin
                    sr_reg    <= SRW'({sr_reg, sin});
                    cnt_reg   <= CW'(1);
                    state_reg <= SHIFT;
                    busy      <= 1'b1;
                end else begin
                    case (state_reg)
                        SHIFT: begin
                            if (cnt_reg == LAST) begin
                                cnt_reg <= '0;
`ifdef SIPO_PARITY_EN
                                sr_reg    <= SRW'({sr_reg, sin});
                                state_reg <= PARITY;
`else
                                state_reg <= IDLE;
                                busy      <= 1'b0;
                                if (slot_free) begin
                                    pout       <= frame_word;
                                    pout_valid <= 1'b1;
                                end else begin
                                    overrun <= 1'b1;
                                end
`endif
                            end else begin
                                sr_reg  <= SRW'({sr_reg, sin});
                                cnt_reg <= cnt_reg + CW'(1);
                            end
                        end
`ifdef SIPO_PARITY_EN
                        PARITY: begin
                            state_reg <= IDLE;
                            busy      <= 1'b0;
                            if (slot_free) begin
                                pout       <= frame_word;
                                pout_valid <= 1'b1;
                                parity_reg <= frame_par;
                            end else begin
                                overrun <= 1'b1;
                            end
                        end
`endif
                        default: begin
                            state_reg <= IDLE;
                            cnt_reg   <= '0;
                            busy      <= 1'b0;
                        end
                    endcase
                end
            end
        end
    end

endmodule

// File: doc/sipo_rx.md
# sipo_rx

Serial-in, parallel-out receiver that reassembles a WIDTH-bit word from a one-bit serial stream, MSB first. It sits at the far end of the team's parallel-in/serial-out shift link. It collects qualified serial bits, presents each completed word on a registered parallel output under a valid/ready handshake, and flags words lost to back-pressure.

## Interface
Parameters:
- WIDTH, default 4: data bits per word (≥2).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- sin  input  1  serial data bit.
- sin_valid  input  1  qualifies sin; a bit is sampled only on edges where this is high.
- sin_start  input  1  frame alignment; marks the sampled bit as bit 0 (MSB) of a new word.
- pout  output  WIDTH  received word, MSB = first bit received.
- pout_valid  output  1  pout holds an unconsumed word.
- pout_ready  input  1  consumer accepts pout when high together with pout_valid.
- busy  output  1  a partial word is in the shift register.
- overrun  output  1  sticky; a completed word was dropped because the output slot was full.
- overrun_clr  input  1  clears overrun.
- parity_err  output  1  see Configuration; constant 0 when the feature is compiled out.

## Operation
- Shift register sr[WIDTH-1:0] and bit counter cnt (0..WIDTH-1, plus a parity slot when enabled).
- Each sampled bit updates sr <= {sr[WIDTH-2:0], sin}.
- States:
  - IDLE: cnt=0, busy=0. Any sampled bit moves to SHIFT with cnt=1.
  - SHIFT: each sampled bit increments cnt. On the WIDTH-th data bit, the word completes and the state returns to IDLE, or moves to PARITY when enabled.
  - PARITY: the next sampled bit completes the word; the state returns to IDLE.
- Word completion:
  - If the output slot is free, or is being freed this cycle (pout_valid && pout_ready), load pout and set pout_valid.
  - Otherwise discard the word, set overrun, and leave pout and pout_valid untouched.
- Handshake:
  - pout_valid falls on the edge where pout_valid && pout_ready, unless a new word loads on that same edge; in that case pout_valid stays high with the new data.
  - pout is stable while pout_valid=1 and not accepted.
- sin_start with sin_valid: any partial word is silently discarded (no overrun). The sampled bit becomes the first bit, cnt=1. This has priority over completion.
- sin_start without sin_valid: ignored.
- overrun_clr: clears overrun. If an overrun event occurs on the same edge, overrun ends set.
- busy = 1 whenever cnt≠0 or the state is PARITY.

## Timing
- Reset values: pout=0, pout_valid=0, busy=0, overrun=0, parity_err=0; sr=0, cnt=0, state IDLE.
- Reset asserted mid-word clears all state immediately. The next word needs a full WIDTH (+1) sampled bits.
- Latency: pout_valid rises on the clock edge that samples the final bit. It is visible in the cycle immediately following that bit.
- Gaps in sin_valid of any length are allowed between bits. There is no timeout.
- Throughput: one word per WIDTH sampled bits with no bubble, provided pout_ready is high.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Configuration
- SIPO_PARITY_EN defined:
  - Each frame is WIDTH data bits followed by one even-parity bit; the PARITY state is active.
  - On completion, parity_err <= ^{word, parity bit} and loads together with pout.
  - The word is delivered regardless of parity.
  - parity_err is valid while pout_valid=1.
  - A dropped word does not update parity_err.
- SIPO_PARITY_EN undefined:
  - Frames are exactly WIDTH bits and the PARITY state is absent.
  - parity_err is tied to 0.

## Test plan
- Basic receive (WIDTH=4, pout_ready=1): sin_start with bits 1,0,1,1 on consecutive cycles -> pout=4'b1011, pout_valid high for exactly one cycle after the 4th bit, busy low afterwards.
- Gapped input: bits 0,1,1,0 with 3 idle cycles between each -> pout=4'b0110, busy high from the 1st bit until completion.
- Back-pressure: pout_ready=0, send 4'b1100 then 4'b0011 -> pout holds 4'b1100, overrun=1. Then pout_ready=1 for one cycle -> pout_valid=0. overrun_clr -> overrun=0.
- Realignment: send bits 1,1 then sin_start with bits 0,1,0,1 -> single word pout=4'b0101, overrun=0.
- Simultaneous accept and complete: hold word 4'b1111 and send the next word 4'b0001, with pout_ready=1 on its last-bit edge -> pout=4'b0001, pout_valid stays 1, overrun=0.
- Reset mid-word and parity (SIPO_PARITY_EN): reset after 2 bits -> all outputs 0. Then send 1,0,1,1 with parity 1 -> parity_err=0. Send 1,0,1,1 with parity 0 -> parity_err=1, pout=4'b1011.
